pipe_skid_buffer: RTL and testbench

- Two-entry valid/ready elastic stage that sits directly upstream of the enable-driven pipeline register.
- Converts a valid/ready producer interface into a registered output, with full throughput and a registered ready_in.
- Breaks the combinational ready path between consumer and producer.
- Downstream enable-style registers can be driven with enable = valid_out && ready_out.

---
 rtl/pipe_skid_buffer_pkg.sv | 13 +
 rtl/pipe_skid_buffer_if.sv | 32 +++
 rtl/pipe_skid_buffer.sv | 134 +++++++++++++
 tb/tb_pipe_skid_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_buffer_pkg.sv
// Shared types and constants for the two-entry valid/ready skid buffer.
// Imported by the top module to get the state encoding and counter width.
package pipe_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// Valid/ready handshake bundle for the skid buffer: producer side (*_in) and consumer side (*_out).
// The slave modport is the buffer; the master modport is whoever drives the producer and consumer.
interface pipe_skid_buffer_if #(
  parameter int DATAW = 1
);

  logic             valid_in;
  logic             ready_in;
  logic [DATAW-1:0] data_in;
  logic             valid_out;
  logic             ready_out;
  logic [DATAW-1:0] data_out;

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_out,
    output ready_in,
    output valid_out,
    output data_out
  );

  modport master (
    output valid_in,
    output data_in,
    output ready_out,
    input  ready_in,
    input  valid_out,
    input  data_out
  );

endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic stage with registered ready_in and valid_out, strict FIFO order.
// Optional consumer-stall counter is enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_buffer
  import pipe_skid_pkg::*;
#(
  parameter int DATAW    = 1,
  parameter int RESETW   = 0,
  parameter int PASSTHRU = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_skid_buffer_if.slave      bus,
  output logic [STALL_CNT_W-1:0] stall_count
);

  if (PASSTHRU != 0) begin : g_passthru
    logic unused_clk_reset;

    assign unused_clk_reset = clk ^ reset;
    assign bus.valid_out    = bus.valid_in;
    assign bus.ready_in     = bus.ready_out;
    assign bus.data_out     = bus.data_in;
    assign stall_count      = '0;
  end else begin : g_registered
    skid_state_e      state_q, state_d;
    logic             rst_done_q;
    logic             valid_int, ready_int;
    logic             push, pop;
    logic             main_load, skid_load, main_from_skid;
    logic [DATAW-1:0] main_q, skid_q, main_d;

    // ready_in stays low until the first edge after reset release.
    assign valid_int = (state_q != EMPTY);
    assign ready_int = (state_q != FULL) && rst_done_q;
    assign push      = bus.valid_in && ready_int;
    assign pop       = valid_int && bus.ready_out;
    assign main_d    = main_from_skid ? skid_q : bus.data_in;

    assign bus.valid_out = valid_int;
    assign bus.ready_in  = ready_int;
    assign bus.data_out  = main_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q    <= EMPTY;
        rst_done_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        rst_done_q <= 1'b1;
      end
    end

    always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // ready_in is low here, so only a pop can move the state.
          if (pop) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Only the top RESETW bits of each data register see the reset.
    if (RESETW > 0) begin : g_rst_bits
      logic [RESETW-1:0] main_hi_q, skid_hi_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          main_hi_q <= '0;
          skid_hi_q <= '0;
        end else begin
          if (main_load) main_hi_q <= main_d[DATAW-1 -: RESETW];
          if (skid_load) skid_hi_q <= bus.data_in[DATAW-1 -: RESETW];
        end
      end

      assign main_q[DATAW-1 -: RESETW] = main_hi_q;
      assign skid_q[DATAW-1 -: RESETW] = skid_hi_q;
    end

    if (RESETW < DATAW) begin : g_norst_bits
      logic [DATAW-RESETW-1:0] main_lo_q, skid_lo_q;

      always_ff @(posedge clk) begin
        if (main_load) main_lo_q <= main_d[DATAW-RESETW-1:0];
        if (skid_load) skid_lo_q <= bus.data_in[DATAW-RESETW-1:0];
      end

      assign main_q[DATAW-RESETW-1:0] = main_lo_q;
      assign skid_q[DATAW-RESETW-1:0] = skid_lo_q;
    end

`ifdef PIPE_SKID_PERF_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stall_q <= '0;
      end else if (valid_int && !bus.ready_out && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_CNT_W'(1);
      end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: registered instance (DATAW=8, RESETW=8) and a PASSTHRU instance.
// A negedge scoreboard checks FIFO order on every pop; each test task checks its own cycle-level details.
module tb_pipe_skid_buffer;
  import pipe_skid_pkg::*;

  logic clk;
  logic reset;
  logic [STALL_CNT_W-1:0] stall_count;
  logic [STALL_CNT_W-1:0] p_stall_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  pipe_skid_buffer_if #(.DATAW(8)) bus ();
  pipe_skid_buffer_if #(.DATAW(8)) p_bus ();

  pipe_skid_buffer #(.DATAW(8), .RESETW(8), .PASSTHRU(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .stall_count (stall_count)
  );

  pipe_skid_buffer #(.DATAW(8), .RESETW(0), .PASSTHRU(1)) dut_pass (
    .clk         (clk),
    .reset       (reset),
    .bus         (p_bus.slave),
    .stall_count (p_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs change at posedge+1, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (!reset) begin
      sb_q.delete();
    end else begin
      if (bus.valid_out && bus.ready_out) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected_pop got %h want none", bus.data_out);
        end else begin
          exp = sb_q.pop_front();
          if (bus.data_out !== exp) begin
            errors++;
            $display("[TB] FAIL sb_order got %h want %h", bus.data_out, exp);
          end
        end
      end
      if (bus.valid_in && bus.ready_in) sb_q.push_back(bus.data_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.valid_in  = 1'b1;
    bus.data_in   = 8'hAA;
    bus.ready_out = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ready_in !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready_in got %b want 0", bus.ready_in); end
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid_out got %b want 0", bus.valid_out); end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.ready_in !== 1'b1) begin errors++; $display("[TB] FAIL rel_ready_in got %b want 1", bus.ready_in); end
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rel_valid_out got %b want 0", bus.valid_out); end
    tick();
    bus.valid_in = 1'b0;
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL first_push got v=%b d=%h want v=1 d=aa", bus.valid_out, bus.data_out);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL first_drain got %b want 0", bus.valid_out); end
  endtask

  task automatic test_streaming();
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.data_in = 8'(i);
      tick();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.ready_in !== 1'b1 || bus.data_out !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL stream_%0d got v=%b r=%b d=%h want v=1 r=1 d=%h",
                 i, bus.valid_out, bus.ready_in, bus.data_out, 8'(i));
      end
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain got %b want 0", bus.valid_out); end
  endtask

  task automatic test_skid_fill();
    bus.ready_out = 1'b0;
    bus.valid_in  = 1'b1;
    bus.data_in   = 8'h11;
    tick();
    bus.data_in = 8'h22;
    tick();
    checks++;
    if (bus.ready_in !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== 8'h11) begin
      errors++;
      $display("[TB] FAIL skid_full got r=%b v=%b d=%h want r=0 v=1 d=11", bus.ready_in, bus.valid_out, bus.data_out);
    end
    // Producer wiggles while blocked; none of this may enter the buffer.
    bus.data_in = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.ready_in !== 1'b0 || bus.data_out !== 8'h11) begin
        errors++;
        $display("[TB] FAIL skid_hold got r=%b d=%h want r=0 d=11", bus.ready_in, bus.data_out);
      end
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    tick();
    checks++;
    if (bus.ready_in !== 1'b1 || bus.valid_out !== 1'b1 || bus.data_out !== 8'h22) begin
      errors++;
      $display("[TB] FAIL skid_unload got r=%b v=%b d=%h want r=1 v=1 d=22", bus.ready_in, bus.valid_out, bus.data_out);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL skid_drain got %b want 0", bus.valid_out); end
  endtask

  task automatic test_push_pop();
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = 8'h33;
    tick();
    bus.data_in = 8'h44;
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.ready_in !== 1'b1 || bus.data_out !== 8'h44) begin
      errors++;
      $display("[TB] FAIL push_pop got v=%b r=%b d=%h want v=1 r=1 d=44", bus.valid_out, bus.ready_in, bus.data_out);
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL push_pop_drain got %b want 0", bus.valid_out); end
  endtask

  task automatic test_reset_midop();
    bus.ready_out = 1'b0;
    bus.valid_in  = 1'b1;
    bus.data_in   = 8'h55;
    tick();
    bus.data_in = 8'h66;
    tick();
    bus.valid_in = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b0 || bus.data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst got v=%b r=%b d=%h want v=0 r=0 d=00", bus.valid_out, bus.ready_in, bus.data_out);
    end
    tick();
    reset         = 1'b1;
    bus.ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.valid_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_flush got v=%b d=%h want v=0", bus.valid_out, bus.data_out);
      end
    end
  endtask

  task automatic test_stall_count();
    logic [STALL_CNT_W-1:0] exp;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (stall_count !== '0) begin errors++; $display("[TB] FAIL stall_reset got %0d want 0", stall_count); end
    bus.ready_out = 1'b0;
    bus.valid_in  = 1'b1;
    bus.data_in   = 8'h77;
    tick();
    bus.valid_in = 1'b0;
    repeat (7) tick();
`ifdef PIPE_SKID_PERF_EN
    exp = 32'd7;
`else
    exp = 32'd0;
`endif
    checks++;
    if (stall_count !== exp) begin errors++; $display("[TB] FAIL stall_count got %0d want %0d", stall_count, exp); end
    bus.ready_out = 1'b1;
    tick();
    checks++;
    if (bus.valid_out !== 1'b0 || stall_count !== exp) begin
      errors++;
      $display("[TB] FAIL stall_release got v=%b cnt=%0d want v=0 cnt=%0d", bus.valid_out, stall_count, exp);
    end
  endtask

  task automatic test_passthru();
    logic       v, r;
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      p_bus.valid_in  = v;
      p_bus.ready_out = r;
      p_bus.data_in   = d;
      #1;
      checks++;
      if (p_bus.valid_out !== v || p_bus.ready_in !== r || p_bus.data_out !== d || p_stall_count !== '0) begin
        errors++;
        $display("[TB] FAIL passthru_%0d got v=%b r=%b d=%h c=%0d want v=%b r=%b d=%h c=0",
                 i, p_bus.valid_out, p_bus.ready_in, p_bus.data_out, p_stall_count, v, r, d);
      end
    end
  endtask

  initial begin
    p_bus.valid_in  = 1'b0;
    p_bus.ready_out = 1'b0;
    p_bus.data_in   = 8'h00;
    test_reset();
    test_streaming();
    test_skid_fill();
    test_push_pop();
    test_reset_midop();
    test_stall_count();
    test_passthru();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
